// File: rtl/gelato_types.sv
// Shared types for the gelato per-warp split-table scheduler.
package gelato_types;

  localparam int NUM_SPLITS = 4;
  localparam int ADDR_W     = 32;

  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [$clog2(NUM_SPLITS)-1:0] split_table_num_t;

  typedef enum logic [1:0] {
    SPLIT_FREE     = 2'd0,
    SPLIT_READY    = 2'd1,
    SPLIT_INFLIGHT = 2'd2,
    SPLIT_STALLED  = 2'd3
  } split_state_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module gelato_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // NUM_REQ is a power of two, so the index add wraps naturally.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr_i + IDX_W'(i);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/gelato_split_table_sched.sv
// Per-warp split table: holds divergent paths, offers READY ones round-robin to fetch,
// and tracks them through update, fork and retire events.
module gelato_split_table_sched #(
  parameter int NUM_SPLITS  = gelato_types::NUM_SPLITS,
  parameter int SPLIT_NUM_W = $clog2(NUM_SPLITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_valid,
  input  gelato_types::addr_t      init_pc,
  output logic                     sel_valid,
  input  logic                     sel_ready,
  output gelato_types::addr_t      sel_pc,
  output logic [SPLIT_NUM_W-1:0]   sel_split_table_num,
  input  logic                     upd_valid,
  input  logic                     upd_stall,
  input  gelato_types::addr_t      upd_pc,
  input  logic [SPLIT_NUM_W-1:0]   upd_split_table_num,
  input  logic                     fork_valid,
  input  gelato_types::addr_t      fork_pc,
  output logic                     fork_ready,
  output logic [SPLIT_NUM_W-1:0]   fork_split_table_num,
  input  logic                     wb_valid,
  input  logic [SPLIT_NUM_W-1:0]   wb_split_table_num,
  output logic [SPLIT_NUM_W:0]     active_count,
  output logic                     idle
);
  import gelato_types::*;

  split_state_t            state_q [NUM_SPLITS];
  split_state_t            state_d [NUM_SPLITS];
  addr_t                   pc_q    [NUM_SPLITS];
  addr_t                   pc_d    [NUM_SPLITS];
  logic [SPLIT_NUM_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_SPLITS-1:0]   ready_req;
  logic [NUM_SPLITS-1:0]   gnt_onehot;
  logic [SPLIT_NUM_W-1:0]  gnt_idx;
  logic                    gnt_any;
  logic                    sel_fire;
  logic                    sel_taken;
  logic                    free_found;

  always_comb begin
    for (int i = 0; i < NUM_SPLITS; i++) begin
      ready_req[i] = (state_q[i] == SPLIT_READY);
    end
  end

  gelato_rr_arbiter #(
    .NUM_REQ (NUM_SPLITS),
    .IDX_W   (SPLIT_NUM_W)
  ) u_arb (
    .req_i     (ready_req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_onehot),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign sel_valid           = gnt_any;
  assign sel_pc              = gnt_any ? pc_q[gnt_idx] : '0;
  assign sel_split_table_num = gnt_any ? gnt_idx : '0;
  assign sel_fire            = gnt_any && sel_ready;

  // Lowest-FREE priority encoder and occupancy count, both from registered state.
  always_comb begin
    free_found           = 1'b0;
    fork_split_table_num = '0;
    active_count         = '0;
    for (int i = 0; i < NUM_SPLITS; i++) begin
      if (state_q[i] == SPLIT_FREE) begin
        if (!free_found) begin
          free_found           = 1'b1;
          fork_split_table_num = SPLIT_NUM_W'(i);
        end
      end else begin
        active_count = active_count + (SPLIT_NUM_W+1)'(1);
      end
    end
    fork_ready = free_found;
    idle       = (active_count == '0);
  end

  // Per-entry event priority: init > wb > update > select > fork.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    sel_taken = 1'b0;
    for (int i = 0; i < NUM_SPLITS; i++) begin
      state_d[i] = state_q[i];
      pc_d[i]    = pc_q[i];
      if (init_valid) begin
        state_d[i] = (i == 0) ? SPLIT_READY : SPLIT_FREE;
        pc_d[i]    = (i == 0) ? init_pc : '0;
      end else if (wb_valid && wb_split_table_num == SPLIT_NUM_W'(i)) begin
        state_d[i] = SPLIT_FREE;
      end else if (upd_valid && upd_split_table_num == SPLIT_NUM_W'(i) &&
                   (state_q[i] == SPLIT_INFLIGHT || state_q[i] == SPLIT_STALLED)) begin
        pc_d[i]    = upd_pc;
        state_d[i] = upd_stall ? SPLIT_STALLED : SPLIT_READY;
      end else if (sel_fire && gnt_onehot[i]) begin
        state_d[i] = SPLIT_INFLIGHT;
        sel_taken  = 1'b1;
      end else if (fork_valid && fork_ready && fork_split_table_num == SPLIT_NUM_W'(i)) begin
        pc_d[i]    = fork_pc;
        state_d[i] = SPLIT_READY;
      end
    end
    if (init_valid) begin
      rr_ptr_d = '0;
    end else if (sel_taken) begin
      rr_ptr_d = gnt_idx + SPLIT_NUM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_SPLITS; i++) begin
        state_q[i] <= SPLIT_FREE;
        pc_q[i]    <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_SPLITS; i++) begin
        state_q[i] <= state_d[i];
        pc_q[i]    <= pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gelato_split_table_sched.sv
// Directed bench for gelato_split_table_sched: per-cycle vector table plus a round-robin sequence.
module tb_gelato_split_table_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_valid;
  logic [31:0] init_pc;
  logic        sel_valid;
  logic        sel_ready;
  logic [31:0] sel_pc;
  logic [1:0]  sel_split_table_num;
  logic        upd_valid;
  logic        upd_stall;
  logic [31:0] upd_pc;
  logic [1:0]  upd_split_table_num;
  logic        fork_valid;
  logic [31:0] fork_pc;
  logic        fork_ready;
  logic [1:0]  fork_split_table_num;
  logic        wb_valid;
  logic [1:0]  wb_split_table_num;
  logic [2:0]  active_count;
  logic        idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gelato_split_table_sched dut (
    .clk                  (clk),
    .rst                  (rst),
    .init_valid           (init_valid),
    .init_pc              (init_pc),
    .sel_valid            (sel_valid),
    .sel_ready            (sel_ready),
    .sel_pc               (sel_pc),
    .sel_split_table_num  (sel_split_table_num),
    .upd_valid            (upd_valid),
    .upd_stall            (upd_stall),
    .upd_pc               (upd_pc),
    .upd_split_table_num  (upd_split_table_num),
    .fork_valid           (fork_valid),
    .fork_pc              (fork_pc),
    .fork_ready           (fork_ready),
    .fork_split_table_num (fork_split_table_num),
    .wb_valid             (wb_valid),
    .wb_split_table_num   (wb_split_table_num),
    .active_count         (active_count),
    .idle                 (idle)
  );

  typedef struct {
    bit          rst;
    bit          init;
    logic [31:0] ipc;
    bit          srdy;
    bit          uv;
    bit          us;
    logic [31:0] upc;
    logic [1:0]  un;
    bit          fv;
    logic [31:0] fpc;
    bit          wv;
    logic [1:0]  wn;
    bit          e_sv;
    logic [31:0] e_pc;
    logic [1:0]  e_sn;
    bit          e_fr;
    logic [1:0]  e_fn;
    logic [2:0]  e_ac;
  } vec_t;

  vec_t q[$];
  vec_t v;
  vec_t z;

  function automatic vec_t ex(vec_t in, bit sv, logic [31:0] spc, logic [1:0] sn,
                              bit fr, logic [1:0] fn, logic [2:0] ac);
    vec_t r = in;
    r.e_sv = sv; r.e_pc = spc; r.e_sn = sn;
    r.e_fr = fr; r.e_fn = fn; r.e_ac = ac;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; init_valid = 1'b0; init_pc = '0; sel_ready = 1'b0;
    upd_valid = 1'b0; upd_stall = 1'b0; upd_pc = '0; upd_split_table_num = '0;
    fork_valid = 1'b0; fork_pc = '0; wb_valid = 1'b0; wb_split_table_num = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    z = '{default: 0};

    // reset
    v = z; v.rst = 1;                          q.push_back(ex(v, 0, 0, 0, 1, 0, 0));
    // init, handshake, update
    v = z; v.init = 1; v.ipc = 'h1000;         q.push_back(ex(v, 1, 'h1000, 0, 1, 1, 1));
    v = z; v.srdy = 1;                         q.push_back(ex(v, 0, 0, 0, 1, 1, 1));
    v = z; v.uv = 1; v.upc = 'h1004; v.un = 0; q.push_back(ex(v, 1, 'h1004, 0, 1, 1, 1));
    // re-init over an active entry, then fill the table
    v = z; v.init = 1; v.ipc = 'h1000;         q.push_back(ex(v, 1, 'h1000, 0, 1, 1, 1));
    v = z; v.fv = 1; v.fpc = 'h2000;           q.push_back(ex(v, 1, 'h1000, 0, 1, 2, 2));
    v = z; v.fv = 1; v.fpc = 'h3000;           q.push_back(ex(v, 1, 'h1000, 0, 1, 3, 3));
    v = z; v.fv = 1; v.fpc = 'h4000;           q.push_back(ex(v, 1, 'h1000, 0, 0, 0, 4));
    // round-robin 0,1,2,3 with sel_ready held
    v = z; v.srdy = 1;                         q.push_back(ex(v, 1, 'h2000, 1, 0, 0, 4));
    v = z; v.srdy = 1;                         q.push_back(ex(v, 1, 'h3000, 2, 0, 0, 4));
    v = z; v.srdy = 1;                         q.push_back(ex(v, 1, 'h4000, 3, 0, 0, 4));
    v = z; v.srdy = 1;                         q.push_back(ex(v, 0, 0, 0, 0, 0, 4));
    // stall entry 1; entry 2 comes back and is taken while 1 stays hidden
    v = z; v.uv = 1; v.us = 1; v.upc = 'h2040; v.un = 1; q.push_back(ex(v, 0, 0, 0, 0, 0, 4));
    v = z; v.uv = 1; v.upc = 'h3008; v.un = 2; q.push_back(ex(v, 1, 'h3008, 2, 0, 0, 4));
    v = z; v.srdy = 1;                         q.push_back(ex(v, 0, 0, 0, 0, 0, 4));
    v = z; v.uv = 1; v.upc = 'h2044; v.un = 1; q.push_back(ex(v, 1, 'h2044, 1, 0, 0, 4));
    v = z; v.uv = 1; v.upc = 'h1010; v.un = 0; q.push_back(ex(v, 1, 'h1010, 0, 0, 0, 4));
    // update on a READY entry is ignored
    v = z; v.uv = 1; v.us = 1; v.upc = 'h5555; v.un = 0; q.push_back(ex(v, 1, 'h1010, 0, 0, 0, 4));
    // handshake and retire on the same entry: freed, rr_ptr stays at 3
    v = z; v.srdy = 1; v.wv = 1; v.wn = 0;     q.push_back(ex(v, 1, 'h2044, 1, 1, 0, 3));
    v = z; v.uv = 1; v.upc = 'h4004; v.un = 3; q.push_back(ex(v, 1, 'h4004, 3, 1, 0, 3));
    // update on a FREE entry is ignored
    v = z; v.uv = 1; v.upc = 'h7777; v.un = 0; q.push_back(ex(v, 1, 'h4004, 3, 1, 0, 3));
    // reset mid-run beats concurrent fork and handshake
    v = z; v.rst = 1; v.fv = 1; v.fpc = 'h8000; v.srdy = 1; q.push_back(ex(v, 0, 0, 0, 1, 0, 0));
    // full table: fork dropped; wb and fork together: fork dropped, next fork takes 0
    v = z; v.init = 1; v.ipc = 'h100;          q.push_back(ex(v, 1, 'h100, 0, 1, 1, 1));
    v = z; v.fv = 1; v.fpc = 'h200;            q.push_back(ex(v, 1, 'h100, 0, 1, 2, 2));
    v = z; v.fv = 1; v.fpc = 'h300;            q.push_back(ex(v, 1, 'h100, 0, 1, 3, 3));
    v = z; v.fv = 1; v.fpc = 'h400;            q.push_back(ex(v, 1, 'h100, 0, 0, 0, 4));
    v = z; v.fv = 1; v.fpc = 'h500;            q.push_back(ex(v, 1, 'h100, 0, 0, 0, 4));
    v = z; v.wv = 1; v.wn = 0; v.fv = 1; v.fpc = 'h600; q.push_back(ex(v, 1, 'h200, 1, 1, 0, 3));
    v = z; v.fv = 1; v.fpc = 'h700;            q.push_back(ex(v, 1, 'h700, 0, 0, 0, 4));
    // rst has priority over init
    v = z; v.rst = 1; v.init = 1; v.ipc = 'h900; q.push_back(ex(v, 0, 0, 0, 1, 0, 0));

    for (int n = 0; n < q.size(); n++) begin
      @(negedge clk);
      rst = q[n].rst; init_valid = q[n].init; init_pc = q[n].ipc; sel_ready = q[n].srdy;
      upd_valid = q[n].uv; upd_stall = q[n].us; upd_pc = q[n].upc; upd_split_table_num = q[n].un;
      fork_valid = q[n].fv; fork_pc = q[n].fpc; wb_valid = q[n].wv; wb_split_table_num = q[n].wn;
      @(posedge clk); #1;
      chk($sformatf("v%0d sel_valid", n), 32'(sel_valid), 32'(q[n].e_sv));
      chk($sformatf("v%0d sel_pc", n), sel_pc, q[n].e_pc);
      chk($sformatf("v%0d sel_num", n), 32'(sel_split_table_num), 32'(q[n].e_sn));
      chk($sformatf("v%0d fork_ready", n), 32'(fork_ready), 32'(q[n].e_fr));
      chk($sformatf("v%0d fork_num", n), 32'(fork_split_table_num), 32'(q[n].e_fn));
      chk($sformatf("v%0d active_count", n), 32'(active_count), 32'(q[n].e_ac));
      chk($sformatf("v%0d idle", n), 32'(idle), 32'(q[n].e_ac == 0));
    end

    // Fairness: three paths, each granted path is returned READY on the next cycle.
    @(negedge clk); drive_idle(); init_valid = 1'b1; init_pc = 'h10;
    @(negedge clk); drive_idle(); fork_valid = 1'b1; fork_pc = 'h20;
    @(negedge clk); drive_idle(); fork_valid = 1'b1; fork_pc = 'h30;
    @(negedge clk); drive_idle();
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("rr%0d sel_num", c), 32'(sel_split_table_num), 32'(c % 3));
      chk($sformatf("rr%0d sel_pc", c), sel_pc, 32'((c % 3 + 1) * 16));
      sel_ready = 1'b1;
      upd_valid = (c > 0);
      upd_split_table_num = 2'((c + 2) % 3);
      upd_pc = 32'(((c + 2) % 3 + 1) * 16);
      @(posedge clk); #1;
      @(negedge clk);
    end
    drive_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
